// File: rtl/auto_clear_ctrl.sv
// Per-bit self-clearing control register: written 1s raise a bit that drops either
// after a fixed pulse width (timer mode) or on acknowledge / timeout (ack mode).
module auto_clear_ctrl #(
    parameter int               WIDTH        = 8,
    parameter int               PULSE_CYCLES = 1,
    parameter logic [WIDTH-1:0] ACK_MASK     = '0,
    parameter int               TIMEOUT      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Wr_en,
    input  logic [WIDTH-1:0] Wr_data,
    input  logic [WIDTH-1:0] Ack,
    input  logic [WIDTH-1:0] Flag_clr,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] Timeout_flag,
    output logic             Busy
);

    localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] flag_q;
    logic [WIDTH-1:0] flag_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // The counter holds the number of high cycles still remaining, so the bit
    // drops on the edge where it reads 1. An ack on that same edge beats the timeout.
    always_comb begin
        out_d  = out_q;
        flag_d = flag_q & ~Flag_clr;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!out_q[i]) begin
                if (Wr_en && Wr_data[i]) begin
                    out_d[i] = 1'b1;
                    cnt_d[i] = ACK_MASK[i] ? TIMEOUT_LD : PULSE_LD;
                end
            end else if (ACK_MASK[i] && Ack[i]) begin
                out_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i] = 1'b0;
                cnt_d[i] = '0;
                if (ACK_MASK[i]) begin
                    flag_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_q  <= '0;
            flag_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q  <= out_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Out          = out_q;
    assign Timeout_flag = flag_q;
    assign Busy         = |out_q;

endmodule

// File: doc/auto_clear_ctrl.md
AUTO_CLEAR_CTRL -- requirements
Module: auto_clear_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent control bits.
REQ-002 SHALL have parameter PULSE_CYCLES, default 1: high time of timer-mode bits; legal range >= 1.
REQ-003 SHALL have parameter ACK_MASK [WIDTH-1:0], default 0: bit i = 1 selects ack mode for bit i; 0 selects timer mode.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum high time of ack-mode bits; legal range >= 1.
REQ-005 SHALL have port Clk, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port Rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port Wr_en, input, 1: write strobe for Wr_data.
REQ-008 SHALL have port Wr_data, input, WIDTH: write-1-to-trigger; 0 bits have no effect.
REQ-009 SHALL have port Ack, input, WIDTH: per-bit completion acknowledge for ack-mode bits.
REQ-010 SHALL have port Flag_clr, input, WIDTH: write-1-to-clear for Timeout_flag; acts without Wr_en.
REQ-011 SHALL have port Out, output, WIDTH: registered self-clearing control bits.
REQ-012 SHALL have port Timeout_flag, output, WIDTH: registered sticky timeout status.
REQ-013 SHALL have port Busy, output, 1: OR of all Out bits, combinational from the Out registers.

Function
REQ-014 SHALL give each bit an independent down-counter sized $clog2(max(PULSE_CYCLES,TIMEOUT)+1).
REQ-015 SHALL arm an idle bit i (Out[i]=0) when Wr_en=1 and Wr_data[i]=1 at an edge; Out[i]=1 from the next cycle.
REQ-016 SHALL ignore trigger writes to a bit already high: no retrigger and no counter reload.
REQ-017 Timer mode: SHALL hold Out[i] high for exactly PULSE_CYCLES consecutive cycles, then clear it; Ack[i] is ignored.
REQ-018 Ack mode: SHALL clear Out[i] on the edge after Ack[i]=1 is sampled while Out[i]=1.
REQ-019 Ack mode: SHALL clear Out[i] after exactly TIMEOUT high cycles without ack, and set Timeout_flag[i] on that same edge.
REQ-020 SHALL ignore Ack[i] while Out[i]=0, including in the cycle in which the bit is armed.
REQ-021 Ack sampled on the edge at which the timeout expires: SHALL take priority; Out[i] clears and Timeout_flag[i] is not set.
REQ-022 Timeout_flag[i] SHALL remain 1 until Flag_clr[i]=1 is sampled; it clears on the next edge.
REQ-023 Flag_clr[i] and a new timeout on the same edge: set SHALL win and the flag remains 1.
REQ-024 A bit that has just cleared SHALL be re-armable by a write on the very next edge, with no dead cycle.
REQ-025 With PULSE_CYCLES=1 and ACK_MASK=0, SHALL produce single-cycle pulses per written bit.
REQ-026 SHALL make all outputs glitch-free registered values, except Busy (see REQ-013).

Reset
REQ-027 While Rst=1 at an edge, SHALL set Out, Timeout_flag and all counters to 0; Busy is therefore 0.
REQ-028 SHALL ignore Wr_en, Ack and Flag_clr in any cycle where Rst=1.
REQ-029 Reset asserted mid-pulse or mid-wait SHALL abort the operation with no timeout flag; operation resumes normally on the first edge with Rst=0.

Verification
Configuration for all scenarios: WIDTH=4, PULSE_CYCLES=3, ACK_MASK=4'b1100, TIMEOUT=5; write sampled at edge 0.
REQ-030 Timer pulse: Wr_data=4'b0001 -> Out=4'b0001 and Busy=1 in cycles 1-3; Out=0 and Busy=0 in cycle 4.
REQ-031 No retrigger: as REQ-030, plus a second write of 4'b0001 at edge 2 -> Out[0] still falls in cycle 4.
REQ-032 Ack: Wr_data=4'b0100, Ack=4'b0100 at edge 3 -> Out[2]=1 in cycles 1-3, 0 in cycle 4; Timeout_flag=0.
REQ-033 Timeout: Wr_data=4'b1000, no ack -> Out[3]=1 in cycles 1-5, 0 in cycle 6; Timeout_flag=4'b1000 from cycle 6; Flag_clr=4'b1000 at edge 8 -> flag 0 in cycle 9.
REQ-034 Ack/timeout collision: as REQ-033 but Ack[3]=1 at edge 5 -> Out[3] falls in cycle 6 and Timeout_flag stays 0.
REQ-035 Reset mid-op: write 4'b1101, Rst=1 at edge 2 together with another write -> Out=0, Timeout_flag=0, Busy=0 in cycle 3; no flags set afterwards.
